// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: commit-trace FIFO downstream of single_cycle_mips.
// Captures register write-backs (and, with TRACE_STORE_EN defined, data
// stores) into a DEPTH-entry FIFO drained over a valid/ready port.
// Optional feature macro: TRACE_STORE_EN.
module wb_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int PC_W   = 10,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     capture_en,
    input  logic [PC_W-1:0]          pc,
    input  logic                     reg_write,
    input  logic [REG_W-1:0]         write_reg,
    input  logic [DATA_W-1:0]        write_back,
    input  logic                     mem_write,
    input  logic [DATA_W-1:0]        mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic                     trace_kind,
    output logic [PC_W-1:0]          trace_pc,
    output logic [DATA_W-1:0]        trace_dst,
    output logic [DATA_W-1:0]        trace_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [PC_W-1:0]   pc_mem   [DEPTH];
    logic [DATA_W-1:0] dst_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic              reg_ev;
    logic              st_ev;
    logic              push_ev;
    logic              pop;
    logic              full;
    logic              accept;
    logic [1:0]        drops;
    logic [DATA_W-1:0] push_dst;
    logic [DATA_W-1:0] push_data;
    logic [8:0]        drop_sum;

`ifdef TRACE_STORE_EN
    logic kind_mem [DEPTH];
    logic push_kind;

    assign st_ev = capture_en & mem_write;
`else
    logic unused_store;

    assign st_ev        = 1'b0;
    assign unused_store = ^{mem_write, mem_addr, mem_data};
`endif

    assign reg_ev      = capture_en & reg_write & (write_reg != '0);
    assign push_ev     = reg_ev | st_ev;
    assign full        = (count == CW'(DEPTH));
    assign trace_valid = (count != '0);
    assign pop         = trace_valid & trace_ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign accept      = push_ev & (~full | pop);
    // Store losing to a register event, plus the whole event lost to a full FIFO.
    assign drops       = {1'b0, reg_ev & st_ev} + {1'b0, push_ev & ~accept};
    assign drop_sum    = {1'b0, drop_count} + 9'(drops);

    // Select the record to push; register events win over stores.
    always_comb begin
        push_dst  = DATA_W'(write_reg);
        push_data = write_back;
`ifdef TRACE_STORE_EN
        push_kind = 1'b0;
        if (!reg_ev) begin
            push_kind = 1'b1;
            push_dst  = mem_addr;
            push_data = mem_data;
        end
`endif
    end

    // Storage array write; contents need no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            pc_mem[wr_ptr]   <= pc;
            dst_mem[wr_ptr]  <= push_dst;
            data_mem[wr_ptr] <= push_data;
`ifdef TRACE_STORE_EN
            kind_mem[wr_ptr] <= push_kind;
`endif
        end
    end

    // Pointers, occupancy and drop accounting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop)
                count <= count + 1'b1;
            else if (!accept && pop)
                count <= count - 1'b1;
            if (drops != '0)
                overflow <= 1'b1;
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // Head record presented combinationally; zeros while empty.
    always_comb begin
        trace_kind = 1'b0;
        trace_pc   = '0;
        trace_dst  = '0;
        trace_data = '0;
        if (trace_valid) begin
`ifdef TRACE_STORE_EN
            trace_kind = kind_mem[rd_ptr];
`endif
            trace_pc   = pc_mem[rd_ptr];
            trace_dst  = dst_mem[rd_ptr];
            trace_data = data_mem[rd_ptr];
        end
    end

endmodule
